pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Parametrised PLL start-up and reset sequencer; the next-generation companion for every PLL wrapper in the design.
- Runs on the free-running board reference clock and drives the PLL's active-low RESETB.
- Qualifies the asynchronous LOCK output and releases NCH downstream reset domains in order.
- Detects lock loss and re-sequences; retries on lock timeout, then reports a hard failure.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_resetb is held low per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAITLOCK before the attempt fails (>=2).
- NCH, 2: number of sequenced reset outputs (1..8).
- STAGE_GAP, 16: cycles between consecutive channel releases (>=1).
- MAX_RETRIES, 3: failed attempts allowed before entering FAIL (>=0).
- SYNC_STAGES, 2: flops in the lock_async synchroniser (>=2).

Ports:
- clk  in  1  reference clock, free-running, never from the PLL.
- reset  in  1  asynchronous, active-low block reset.
- lock_async  in  1  PLL LOCK, asynchronous to clk.
- restart  in  1  synchronous one-cycle pulse requesting a full re-sequence.
- pll_resetb  out  1  to PLL RESETB, active-low.
- rst_n_out  out  NCH  per-channel active-low resets; bit 0 releases first.
- ready  out  1  high when all channels are released and lock is held.
- fail  out  1  sticky retry-exhaustion flag.
- relock_count  out  8  saturating count of lock-loss events seen in RUN.
- state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset asserted: state=PLLRST, pll_resetb=0, rst_n_out=all 0, ready=0, fail=0, relock_count=0, counters=0, retry count=0, synchroniser cleared.
- lock_s is lock_async after SYNC_STAGES flops. All FSM decisions use lock_s only.
- One down/up counter of width clog2(max of the cycle parameters)+1 is shared by all states and cleared on every state entry.
- State encodings: PLLRST=0, WAITLOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- PLLRST:
  - pll_resetb=0 and rst_n_out=0.
  - After exactly PLL_RST_CYCLES cycles in the state, go to WAITLOCK.
- WAITLOCK:
  - pll_resetb=1.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: retry count +1.
    - If the retry count now exceeds MAX_RETRIES, go to FAIL.
    - Otherwise go to PLLRST.
- STABLE:
  - lock_s=0 at any cycle: return to WAITLOCK. The timeout counter restarts; this is not a retry.
  - LOCK_STABLE_CYCLES consecutive lock_s=1 cycles: go to RELEASE.
- RELEASE:
  - rst_n_out[k] goes high at RELEASE-entry + k*STAGE_GAP cycles, so bit 0 goes high on the first RELEASE cycle.
  - After the last bit is released, go to RUN on the next cycle.
  - lock_s=0 during RELEASE: handled as a RUN lock loss.
- RUN:
  - ready=1, retry count cleared.
  - lock_s=0: relock_count +1 (saturates at 255), all rst_n_out drop to 0 the same cycle, ready=0, go to PLLRST.
- FAIL:
  - pll_resetb=0, rst_n_out=0, fail=1.
  - Stays in FAIL until reset asserts or restart pulses.
  - restart clears fail and the retry count and goes to PLLRST. relock_count is not cleared.
- restart in any state: go to PLLRST next cycle and drop all rst_n_out the same cycle. restart has priority over every other transition.
- rst_n_out and ready are registered. A bit never rises out of order and never glitches.
- All channel deasserts are simultaneous.

Test Plan:
- Params 4/8/64/NCH=3/STAGE_GAP=2/RETRIES=1:
  - Release reset, lock_async rises at cycle 10 -> pll_resetb high at cycle 4.
  - rst_n_out bits rise 2 cycles apart, in order 0,1,2.
  - ready rises after bit 2; relock_count=0.
- Lock glitch: lock_async low for 1 cycle midway through STABLE -> no channel released, state returns to WAITLOCK, and a full 8 stable cycles are needed again.
- Lock never asserts:
  - Two timeouts of 64 cycles each -> fail=1 and state=5.
  - pll_resetb held low; a restart pulse clears fail and re-enters PLLRST.
- In RUN, drop lock_async -> all rst_n_out low 3 cycles later (SYNC_STAGES + register), ready=0, relock_count=1, then a full re-sequence completes.
- Reset asserted mid-RELEASE with bit 0 already high -> all outputs at reset values immediately (asynchronous); normal sequence after deassert.
- 300 forced lock losses -> relock_count saturates at 255.

Source files
------------

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL start-up, lock qualification and staged reset release sequencer
module pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NCH                 = 2,
  parameter int STAGE_GAP           = 16,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           lock_async,
  input  logic           restart,
  output logic           pll_resetb,
  output logic [NCH-1:0] rst_n_out,
  output logic           ready,
  output logic           fail,
  output logic [7:0]     relock_count,
  output logic [2:0]     state
);

  localparam logic [2:0] ST_PLLRST   = 3'd0;
  localparam logic [2:0] ST_WAITLOCK = 3'd1;
  localparam logic [2:0] ST_STABLE   = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;
  localparam logic [2:0] ST_FAIL     = 3'd5;

  localparam int REL_SPAN = (NCH - 1) * STAGE_GAP;
  localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B    = (LOCK_TIMEOUT_CYCLES > REL_SPAN + 1) ? LOCK_TIMEOUT_CYCLES : REL_SPAN + 1;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAX_C) + 1;
  localparam int RW       = $clog2(MAX_RETRIES + 2);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(REL_SPAN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d, retry_inc;
  logic [7:0]             relock_q, relock_d;
  logic                   pll_resetb_q, pll_resetb_d;
  logic [NCH-1:0]         rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   lock_lost;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign retry_inc = retry_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    relock_d  = relock_q;
    lock_lost = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (int'(retry_inc) > MAX_RETRIES) ? ST_FAIL : ST_PLLRST;
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAITLOCK;
        else if (cnt_q == STB_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!lock_s) lock_lost = 1'b1;
        else if (cnt_q == REL_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        retry_d = '0;
        if (!lock_s) lock_lost = 1'b1;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: state_d = ST_PLLRST;
    endcase

    // restart outranks everything, including counting a lock loss
    if (restart) begin
      state_d = ST_PLLRST;
      retry_d = '0;
    end else if (lock_lost) begin
      state_d = ST_PLLRST;
      if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
    end

    if (restart || (state_d != state_q)) cnt_d = '0;
    else if ((state_q != ST_RUN) && (state_q != ST_FAIL)) cnt_d = cnt_q + 1'b1;
    else cnt_d = cnt_q;

    // outputs are decoded from the next state so they register glitch-free
    pll_resetb_d = (state_d != ST_PLLRST) && (state_d != ST_FAIL);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
    rst_n_d      = '0;
    if (state_d == ST_RUN) begin
      rst_n_d = '1;
    end else if (state_d == ST_RELEASE) begin
      for (int k = 0; k < NCH; k++) rst_n_d[k] = (int'(cnt_d) >= k * STAGE_GAP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      state_q      <= ST_PLLRST;
      cnt_q        <= '0;
      retry_q      <= '0;
      relock_q     <= '0;
      pll_resetb_q <= 1'b0;
      rst_n_q      <= '0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], lock_async};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      relock_q     <= relock_d;
      pll_resetb_q <= pll_resetb_d;
      rst_n_q      <= rst_n_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign rst_n_out    = rst_n_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq output change sequence
module tb_pll_reset_seq;
  logic       clk, reset, lock_async, restart;
  logic       pll_resetb;
  logic [2:0] rst_n_out;
  logic       ready, fail;
  logic [7:0] relock_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_rc;
  bit mon_en = 1'b0;

  typedef struct {
    int          cy;
    logic [16:0] v;
  } exp_t;
  exp_t        sbq[$];
  logic [16:0] prev_v;

  pll_reset_seq #(
    .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(64),
    .NCH(3), .STAGE_GAP(2), .MAX_RETRIES(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .lock_async(lock_async), .restart(restart),
    .pll_resetb(pll_resetb), .rst_n_out(rst_n_out), .ready(ready), .fail(fail),
    .relock_count(relock_count), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] pack(input logic [2:0] st, input logic prb, input logic [2:0] rn,
                                       input logic rdy, input logic fl, input logic [7:0] rc);
    return {st, prb, rn, rdy, fl, rc};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int cy, input logic [2:0] st, input logic prb, input logic [2:0] rn,
                      input logic rdy, input logic fl, input logic [7:0] rc);
    exp_t e;
    e.cy = cy;
    e.v  = pack(st, prb, rn, rdy, fl, rc);
    sbq.push_back(e);
  endtask

  // lock_s already high: STABLE at s, bits every 2 cycles from s+8, RUN at s+13
  task automatic push_from_stable(input int s, input logic [7:0] rc);
    push(s,      3'd2, 1'b1, 3'b000, 1'b0, 1'b0, rc);
    push(s + 8,  3'd3, 1'b1, 3'b001, 1'b0, 1'b0, rc);
    push(s + 10, 3'd3, 1'b1, 3'b011, 1'b0, 1'b0, rc);
    push(s + 12, 3'd3, 1'b1, 3'b111, 1'b0, 1'b0, rc);
    push(s + 13, 3'd4, 1'b1, 3'b111, 1'b1, 1'b0, rc);
  endtask

  task automatic at_cycle(input int n, input int off);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #(off - 1);
  endtask

  task automatic pulse_restart();
    int r;
    r = cyc;
    restart = 1'b1;
    at_cycle(r + 1, 7);
    restart = 1'b0;
  endtask

  // from RUN: drop lock for 3 cycles, expect teardown 3 cycles later and a full re-sequence
  task automatic force_loss();
    int c;
    c = cyc;
    exp_rc = (exp_rc == 255) ? 255 : exp_rc + 1;
    push(c + 3, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'(exp_rc));
    push(c + 7, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'(exp_rc));
    push_from_stable(c + 8, 8'(exp_rc));
    lock_async = 1'b0;
    at_cycle(c + 3, 7);
    lock_async = 1'b1;
    at_cycle(c + 23, 7);
  endtask

  always @(negedge clk) begin : monitor
    logic [16:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = pack(state, pll_resetb, rst_n_out, ready, fail, relock_count);
      if (cur !== prev_v) begin
        if (sbq.size() == 0) begin
          check_eq("sb_unexpected", 32'(cur), 32'(prev_v));
        end else begin
          e = sbq.pop_front();
          check_eq("sb_cycle", cyc, e.cy);
          check_eq("sb_value", 32'(cur), 32'(e.v));
        end
        prev_v = cur;
      end
    end
  end

  initial begin
    int r, d, f, q;
    reset = 1'b1; lock_async = 1'b0; restart = 1'b0; exp_rc = 0;
    #1 reset = 1'b0;
    at_cycle(3, 7);
    check_eq("reset_state", state, 0);
    check_eq("reset_pllrb", pll_resetb, 0);
    check_eq("reset_rst_n", rst_n_out, 0);
    check_eq("reset_ready", ready, 0);
    check_eq("reset_fail", fail, 0);
    check_eq("reset_relock", relock_count, 0);
    prev_v = pack(3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    mon_en = 1'b1;

    // bring-up: reset released in cycle 3, lock at cycle 3+10
    push(7, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
    push_from_stable(16, 8'd0);
    reset = 1'b1;
    at_cycle(13, 7);
    lock_async = 1'b1;
    at_cycle(31, 7);
    check_eq("up_ready", ready, 1);
    check_eq("up_relock", relock_count, 0);

    force_loss();
    check_eq("loss_relock", relock_count, 1);

    // one-cycle lock glitch in the middle of STABLE
    r = cyc;
    push(r + 1,  3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1);
    push(r + 5,  3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
    push(r + 6,  3'd2, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
    push(r + 11, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
    push_from_stable(r + 12, 8'd1);
    pulse_restart();
    at_cycle(r + 8, 7);
    lock_async = 1'b0;
    at_cycle(r + 9, 7);
    lock_async = 1'b1;
    at_cycle(r + 28, 7);

    // lock never returns: two 64-cycle timeouts then FAIL
    d = cyc;
    exp_rc = 2;
    push(d + 3,   3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2);
    push(d + 7,   3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
    push(d + 71,  3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2);
    push(d + 75,  3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
    push(d + 139, 3'd5, 1'b0, 3'b000, 1'b0, 1'b1, 8'd2);
    lock_async = 1'b0;
    at_cycle(d + 160, 7);
    check_eq("fail_flag", fail, 1);
    check_eq("fail_state", state, 5);
    check_eq("fail_pllrb", pll_resetb, 0);
    f = cyc;
    push(f + 1, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2);
    push(f + 5, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
    push_from_stable(f + 6, 8'd2);
    pulse_restart();
    lock_async = 1'b1;
    at_cycle(f + 22, 7);
    check_eq("restart_fail_clr", fail, 0);
    check_eq("restart_ready", ready, 1);

    // asynchronous reset while bit 0 is already released
    r = cyc;
    push(r + 1,  3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2);
    push(r + 5,  3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
    push(r + 6,  3'd2, 1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
    push(r + 14, 3'd3, 1'b1, 3'b001, 1'b0, 1'b0, 8'd2);
    push(r + 15, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    pulse_restart();
    at_cycle(r + 15, 2);
    reset = 1'b0;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_rst_n", rst_n_out, 0);
    check_eq("arst_pllrb", pll_resetb, 0);
    check_eq("arst_relock", relock_count, 0);
    at_cycle(r + 18, 7);
    q = cyc;
    exp_rc = 0;
    push(q + 4, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
    push_from_stable(q + 5, 8'd0);
    reset = 1'b1;
    at_cycle(q + 20, 7);

    for (int i = 0; i < 300; i++) force_loss();
    check_eq("relock_sat", relock_count, 255);
    check_eq("sb_pending", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
